// File: rtl/maxnet_sequencer.sv
// Iteration sequencer for the four-lane Maxnet winner-take-all datapath.
// It loads the operands, then repeats multiply / add / activate until the datapath
// reports a single surviving lane or the iteration budget runs out. abort cancels
// the run at any point.
// Every output is a registered Moore output. The next outputs are decoded from the
// next state, so each output register always matches the state register beside it.
module maxnet_sequencer #(
  parameter int unsigned MAX_ITER = 16,
  parameter int unsigned ITER_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              found,
  output logic              mainRegWrite,
  output logic              s1,
  output logic              s2,
  output logic              s3,
  output logic              s4,
  output logic              multWrite,
  output logic              addWrite,
  output logic              actWrite,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [ITER_W-1:0] MaxIter = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMult,
    StAdd,
    StAct,
    StCheck,
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              timeout_q, timeout_d;
  logic              main_wr_q, main_wr_d;
  logic              sel_q, sel_d;
  logic              mult_wr_q, mult_wr_d;
  logic              add_wr_q, add_wr_d;
  logic              act_wr_q, act_wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next state, iteration count and timeout flag.
  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    timeout_d = timeout_q;
    if (abort && (state_q != StIdle)) begin
      // abort overrides every other transition and leaves iter_count and timeout as they are
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d   = StLoad;
            iter_d    = '0;
            timeout_d = 1'b0;
          end
        end
        StLoad:  state_d = StMult;
        StMult:  state_d = StAdd;
        StAdd:   state_d = StAct;
        StAct: begin
          state_d = StCheck;
          if (iter_q < MaxIter) begin
            iter_d = iter_q + 1'b1;
          end
        end
        StCheck: begin
          if (found) begin
            state_d = StFin;
          end else if (iter_q == MaxIter) begin
            state_d   = StFin;
            timeout_d = 1'b1;
          end else begin
            state_d = StMult;
          end
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Decode the outputs from the next state so that they are registered with it.
  always_comb begin
    main_wr_d = (state_d == StLoad) || (state_d == StAct);
    sel_d     = (state_d == StLoad);
    mult_wr_d = (state_d == StMult);
    add_wr_d  = (state_d == StAdd);
    act_wr_d  = (state_d == StAct);
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StFin);
  end

  // State and output registers; asynchronous reset clears every output immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      iter_q    <= '0;
      timeout_q <= 1'b0;
      main_wr_q <= 1'b0;
      sel_q     <= 1'b0;
      mult_wr_q <= 1'b0;
      add_wr_q  <= 1'b0;
      act_wr_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      timeout_q <= timeout_d;
      main_wr_q <= main_wr_d;
      sel_q     <= sel_d;
      mult_wr_q <= mult_wr_d;
      add_wr_q  <= add_wr_d;
      act_wr_q  <= act_wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mainRegWrite = main_wr_q;
  assign s1           = sel_q;
  assign s2           = sel_q;
  assign s3           = sel_q;
  assign s4           = sel_q;
  assign multWrite    = mult_wr_q;
  assign addWrite     = add_wr_q;
  assign actWrite     = act_wr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign iter_count   = iter_q;

endmodule

// File: tb/tb_maxnet_sequencer.sv
// Self-checking bench for maxnet_sequencer. The expected outputs for each cycle come
// from the cycle arithmetic of a run: LOAD is in cycle 1, iteration i is in cycles
// 4i-2..4i+1, done is in cycle 4N+2, and an abort in cycle a ends the run after cycle a.
module tb_maxnet_sequencer;

  localparam int unsigned MaxIter = 4;
  localparam int unsigned IterW   = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             found = 1'b0;
  logic             mainRegWrite, s1, s2, s3, s4, multWrite, addWrite, actWrite;
  logic             busy, done, timeout;
  logic [IterW-1:0] iter_count;

  int checks = 0;
  int failures = 0;

  maxnet_sequencer #(
    .MAX_ITER(MaxIter),
    .ITER_W  (IterW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .found       (found),
    .mainRegWrite(mainRegWrite),
    .s1          (s1),
    .s2          (s2),
    .s3          (s3),
    .s4          (s4),
    .multWrite   (multWrite),
    .addWrite    (addWrite),
    .actWrite    (actWrite),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .iter_count  (iter_count)
  );

  always #5 clk = ~clk;

  // Field order: mainRegWrite, s1..s4, multWrite, addWrite, actWrite, busy, done, timeout, iter
  function automatic logic [13:0] obs();
    return {mainRegWrite, s1, s2, s3, s4, multWrite, addWrite, actWrite,
            busy, done, timeout, iter_count};
  endfunction

  // One run. found_iter=0 means found is never raised, so the run times out.
  // abort_cyc=0 means there is no abort. The task returns in the first idle cycle
  // after the run, so a caller can issue the next start there.
  task automatic run(input int found_iter, input int abort_cyc, input bit spurious,
                     input string tag, output int n_mult, output int n_add,
                     output int n_act, output int n_done);
    int  n_eff;
    bit  to_run;
    int  done_cyc;
    int  last;
    int  ph;
    int  it;
    logic [13:0] exp_v;
    logic [13:0] got;
    bit  e_mrw, e_sel, e_mw, e_aw, e_actw, e_busy, e_done, e_to;
    to_run   = (found_iter == 0) || (found_iter > int'(MaxIter));
    n_eff    = to_run ? int'(MaxIter) : found_iter;
    done_cyc = 4 * n_eff + 2;
    last     = (abort_cyc != 0) ? abort_cyc : done_cyc;
    n_mult = 0; n_add = 0; n_act = 0; n_done = 0;
    start = 1'b1;
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      found = 1'b0;
      {e_mrw, e_sel, e_mw, e_aw, e_actw, e_busy, e_done, e_to} = '0;
      ph = (c - 2) % 4;
      if (c <= last) begin
        e_busy = 1'b1;
        it = (c - 1) / 4;
        if (it > int'(MaxIter)) it = int'(MaxIter);
        if (c == 1) begin
          e_mrw = 1'b1; e_sel = 1'b1;
        end else if (c == done_cyc) begin
          e_done = 1'b1; e_to = to_run;
        end else begin
          case (ph)
            0: e_mw = 1'b1;
            1: e_aw = 1'b1;
            2: begin e_actw = 1'b1; e_mrw = 1'b1; end
            default: ;
          endcase
        end
      end else begin
        it   = (abort_cyc != 0) ? (abort_cyc - 1) / 4 : n_eff;
        e_to = (abort_cyc == 0) && to_run;
      end
      exp_v = {e_mrw, e_sel, e_sel, e_sel, e_sel, e_mw, e_aw, e_actw, e_busy, e_done, e_to,
               IterW'(it)};
      got = obs();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL %s cycle %0d: outputs got %b required %b", tag, c, got, exp_v);
      end
      n_mult += int'(multWrite);
      n_add  += int'(addWrite);
      n_act  += int'(actWrite);
      n_done += int'(done);
      // Drive this cycle's inputs; they are sampled at the edge that ends it.
      if (c <= last) begin
        if (!to_run && c == 4 * found_iter + 1) found = 1'b1;
        if (spurious) begin
          start = 1'($urandom_range(0, 1));
          if (c >= 2 && ph != 3) found = 1'($urandom_range(0, 1));
        end
        if (c == abort_cyc) abort = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (obs() !== 14'd0) begin
      failures++;
      $display("FAIL reset_hold: outputs got %b required 0", obs());
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== 14'd0) begin
      failures++;
      $display("FAIL reset_release: outputs got %b required 0", obs());
    end
    // Start a run and pull reset in the middle of ACT (cycle 4).
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mainRegWrite, actWrite, busy} !== 3'b111) begin
      failures++;
      $display("FAIL reset_pre_act: mrw/act/busy got %b required 111",
               {mainRegWrite, actWrite, busy});
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obs() !== 14'd0) begin
      failures++;
      $display("FAIL reset_async: outputs got %b required 0", obs());
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== 14'd0) begin
      failures++;
      $display("FAIL reset_idle: outputs got %b required 0", obs());
    end
  endtask

  task automatic test_single();
    int m, a, t, d;
    run(1, 0, 1'b0, "single", m, a, t, d);
    checks++;
    if (d !== 1) begin
      failures++;
      $display("FAIL single_done_count: got %0d required 1", d);
    end
  endtask

  task automatic test_three();
    int m, a, t, d;
    run(3, 0, 1'b0, "three", m, a, t, d);
    checks++;
    if ({m, a, t} !== {32'd3, 32'd3, 32'd3}) begin
      failures++;
      $display("FAIL three_pulses: mult/add/act got %0d/%0d/%0d required 3/3/3", m, a, t);
    end
  endtask

  task automatic test_timeout();
    int m, a, t, d;
    run(0, 0, 1'b0, "timeout", m, a, t, d);
    checks++;
    if (m !== int'(MaxIter) || d !== 1) begin
      failures++;
      $display("FAIL timeout_counts: mult %0d done %0d required %0d and 1", m, d, MaxIter);
    end
    // Back-to-back run: LOAD must already show timeout cleared.
    run(2, 0, 1'b0, "after_timeout", m, a, t, d);
  endtask

  task automatic test_abort();
    int m, a, t, d;
    run(2, 7, 1'b0, "abort", m, a, t, d);
    checks++;
    if (d !== 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d required 0", d);
    end
    run(2, 0, 1'b0, "after_abort", m, a, t, d);
    // abort in the CHECK where found is raised wins over found.
    run(1, 5, 1'b0, "abort_vs_found", m, a, t, d);
  endtask

  task automatic test_spurious();
    int m, a, t, d;
    run(2, 0, 1'b1, "spurious", m, a, t, d);
    checks++;
    if (d !== 1) begin
      failures++;
      $display("FAIL spurious_done_count: got %0d required 1", d);
    end
  endtask

  task automatic test_random();
    int m, a, t, d;
    int fi, n_eff, ab;
    for (int k = 0; k < 24; k++) begin
      fi    = int'($urandom_range(0, MaxIter + 1));
      n_eff = (fi == 0 || fi > int'(MaxIter)) ? int'(MaxIter) : fi;
      ab    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4 * n_eff + 1)) : 0;
      run(fi, ab, 1'($urandom_range(0, 1)), "random", m, a, t, d);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_three();
    test_timeout();
    test_abort();
    test_spurious();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
